infrared_send: RTL and testbench
================================

# infrared_send

NEC infrared transmitter: the transmit-side counterpart of `infrared_rcv`, producing the same baseband waveform that block decodes. On a single-cycle request it serialises a full NEC frame, or an NEC repeat frame, onto a baseband line (idle high, mark low). It also drives an optional 38 kHz modulated LED output. It sits between the user-command logic and the IR LED driver, and loops back directly into `infrared_rcv` for self-test.

## Interface
- US_DIV, 50: `sys_clk` cycles per microsecond (50 MHz); the bench may set 1 to shorten simulation.
- LEAD_MARK_US, 9000: leader mark.
- LEAD_SPACE_US, 4500: leader space, data frame.
- REP_SPACE_US, 2250: leader space, repeat frame.
- BIT_MARK_US, 560: bit mark and stop mark.
- ZERO_SPACE_US, 560: space for bit 0.
- ONE_SPACE_US, 1690: space for bit 1.
- GAP_US, 40000: mandatory idle after each frame.
- CARRIER_HALF, 658: half-period of the carrier in cycles (about 38 kHz at 50 MHz).
- sys_clk  in  1  system clock; one clock domain.
- sys_rst  in  1  reset, asynchronous, active-high.
- send  in  1  start request, sampled only in IDLE.
- repeat_req  in  1  sampled with `send`: 1 sends a repeat frame, 0 sends a data frame.
- addr  in  8  NEC address, latched when `send` is accepted.
- cmd  in  8  NEC command, latched when `send` is accepted.
- busy  out  1  high from acceptance through the end of GAP.
- done  out  1  one-cycle pulse in the cycle `busy` falls.
- infrared_out  out  1  baseband line: 1 = space/idle, 0 = mark.
- ir_led  out  1  carrier-modulated mark: `~infrared_out & carrier`.

## Operation
- States: IDLE, LEAD_MARK, LEAD_SPACE, REP_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
- IDLE with `send`=1:
  - Latch shift register `sr[31:0] = {~cmd, cmd, ~addr, addr}` and the repeat flag.
  - Next state is LEAD_MARK.
- LEAD_MARK goes to REP_SPACE if the repeat flag is set, otherwise to LEAD_SPACE.
- LEAD_SPACE goes to BIT_MARK with bit counter = 0.
- BIT_MARK goes to BIT_SPACE. BIT_SPACE length is `ONE_SPACE_US` when `sr[0]`=1, otherwise `ZERO_SPACE_US`.
- On leaving BIT_SPACE:
  - Shift `sr` right and increment the counter.
  - After bit 31, go to STOP_MARK; otherwise go to BIT_MARK.
- REP_SPACE goes to STOP_MARK.
- STOP_MARK goes to GAP, then GAP goes to IDLE.
- Bits are sent LSB first: addr, ~addr, cmd, ~cmd.
- `infrared_out` = 0 exactly in LEAD_MARK, BIT_MARK and STOP_MARK; 1 elsewhere.
- Carrier:
  - The phase counter restarts on every mark entry, beginning with the high phase.
  - It toggles every CARRIER_HALF cycles and is held at 0 outside marks.
  - `ir_led` = 0 outside marks.
- `send` while busy is ignored; no queueing. `addr`/`cmd` changes after acceptance have no effect.
- Reset (any time, including mid-frame):
  - Immediately: state IDLE, `infrared_out`=1, `ir_led`=0, `busy`=0, `done`=0.
  - `sr`, the bit counter, the µs prescaler and the carrier counter clear.
  - No partial frame resumes.

## Timing
- `send` is accepted at a rising edge. In the following cycle: `busy`=1, `infrared_out`=0, `ir_led`=1.
- Every state except IDLE lasts exactly `<duration>_US × US_DIV` cycles. The µs prescaler (0..US_DIV-1) clears on state entry.
- State durations use a 17-bit µs counter, enough for GAP_US up to 131071.
- A data frame is 67980 µs before GAP for every addr/cmd, because it always contains 16 ones and 16 zeros. At US_DIV=50 that is 3,399,000 cycles.
- A repeat frame is 11810 µs before GAP.
- `done` is high for the last cycle of GAP only. `busy` is 0 the next cycle, and `send` may be accepted in that same cycle.
- `send` and `done` in the same cycle: that `send` is ignored, because the state is GAP, not IDLE.

## Structure
- Package `ir_nec_pkg`:
  - state enum;
  - default µs constants shared with `infrared_rcv`;
  - NEC frame width (32) and repeat-space constant.
- Sub-module `ir_carrier_gen`:
  - Ports: `sys_clk`, `sys_rst`, `en` (mark), `carrier`.
  - Contains the CARRIER_HALF counter and phase flop.
- Top level holds the FSM, µs prescaler, duration counter, shift register and bit counter.

## Test plan
- Reset, then hold idle 1000 cycles → `infrared_out`=1, `ir_led`=0, `busy`=0, `done`=0 throughout.
- US_DIV=50, `send` with addr=0x4D, cmd=0x80:
  - Low pulses at 9000 µs, followed by a 4500 µs high.
  - Then 32 bits 1,0,1,1,0,0,1,0 / 0,1,0,0,1,1,0,1 / 0×7,1 / 1×7,0.
  - `done` at 107980 µs after acceptance.
- Loopback into `infrared_rcv` for 0x4D with cmds 0x80, 0x38, 0x18, 0x08, 0x30 → one `data_valid` per frame, decoded address/command matching, `repeat_en`=0.
- `repeat_req`=1 with `send` → 9000 µs low, 2250 µs high, 560 µs low, then GAP. The receiver asserts `repeat_en`.
- `send` pulsed at the 10th data bit and during GAP → ignored; the waveform is identical to the single-frame capture.
- Assert `sys_rst` mid-BIT_MARK → `infrared_out`=1 and `ir_led`=0 asynchronously. After release, a new `send` produces a clean full frame.

Source files
------------

// File: rtl/ir_nec_pkg.sv
// Shared NEC infrared definitions: FSM states, default microsecond timings
// and frame geometry used by both the transmitter and the receiver.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    REP_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } ir_state_e;

  localparam int NEC_US_DIV         = 50;
  localparam int NEC_LEAD_MARK_US   = 9000;
  localparam int NEC_LEAD_SPACE_US  = 4500;
  localparam int NEC_REP_SPACE_US   = 2250;
  localparam int NEC_BIT_MARK_US    = 560;
  localparam int NEC_ZERO_SPACE_US  = 560;
  localparam int NEC_ONE_SPACE_US   = 1690;
  localparam int NEC_GAP_US         = 40000;
  localparam int NEC_CARRIER_HALF   = 658;

  localparam int NEC_BITS = 32;
  localparam int US_CNT_W = 17;

  // On-air word, shifted out LSB first: addr, ~addr, cmd, ~cmd.
  function automatic logic [NEC_BITS-1:0] nec_frame(input logic [7:0] addr,
                                                    input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

endpackage

// File: rtl/infrared_send_if.sv
// Request/status bundle between user-command logic and the NEC transmitter.
interface infrared_send_if;
  logic       send;
  logic       repeat_req;
  logic [7:0] addr;
  logic [7:0] cmd;
  logic       busy;
  logic       done;
  logic       infrared_out;
  logic       ir_led;

  modport master (
    output send, repeat_req, addr, cmd,
    input  busy, done, infrared_out, ir_led
  );

  modport slave (
    input  send, repeat_req, addr, cmd,
    output busy, done, infrared_out, ir_led
  );
endinterface

// File: rtl/ir_carrier_gen.sv
// Carrier for the IR LED: restarts in its high phase whenever a mark begins,
// and is forced low between marks.
module ir_carrier_gen #(
  parameter int CARRIER_HALF = 658
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  output logic carrier
);
  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  logic [CW-1:0] cnt;
  logic          phase;

  // Phase parks high while idle so the first mark cycle already drives the LED.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CW'(CARRIER_HALF - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign carrier = en & phase;
endmodule

// File: rtl/infrared_send.sv
// NEC infrared transmitter: serialises a data or repeat frame onto an
// idle-high baseband line plus a carrier-modulated LED drive.
module infrared_send
  import ir_nec_pkg::*;
#(
  parameter int US_DIV        = NEC_US_DIV,
  parameter int LEAD_MARK_US  = NEC_LEAD_MARK_US,
  parameter int LEAD_SPACE_US = NEC_LEAD_SPACE_US,
  parameter int REP_SPACE_US  = NEC_REP_SPACE_US,
  parameter int BIT_MARK_US   = NEC_BIT_MARK_US,
  parameter int ZERO_SPACE_US = NEC_ZERO_SPACE_US,
  parameter int ONE_SPACE_US  = NEC_ONE_SPACE_US,
  parameter int GAP_US        = NEC_GAP_US,
  parameter int CARRIER_HALF  = NEC_CARRIER_HALF
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  infrared_send_if.slave ir
);
  localparam int            PW       = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(US_DIV - 1);

  ir_state_e             state, next_state;
  logic [PW-1:0]         pre;
  logic [US_CNT_W-1:0]   us_cnt;
  logic [US_CNT_W-1:0]   dur_us;
  logic [NEC_BITS-1:0]   sr;
  logic [4:0]            bit_cnt;
  logic                  rep;
  logic                  mark;
  logic                  last;
  logic                  carrier;

  // Length of the current state; a bit space is sized by the bit on air.
  always_comb begin
    dur_us = US_CNT_W'(1);
    mark   = 1'b0;
    case (state)
      LEAD_MARK:  begin dur_us = US_CNT_W'(LEAD_MARK_US); mark = 1'b1; end
      LEAD_SPACE: dur_us = US_CNT_W'(LEAD_SPACE_US);
      REP_SPACE:  dur_us = US_CNT_W'(REP_SPACE_US);
      BIT_MARK:   begin dur_us = US_CNT_W'(BIT_MARK_US); mark = 1'b1; end
      BIT_SPACE:  dur_us = sr[0] ? US_CNT_W'(ONE_SPACE_US) : US_CNT_W'(ZERO_SPACE_US);
      STOP_MARK:  begin dur_us = US_CNT_W'(BIT_MARK_US); mark = 1'b1; end
      GAP:        dur_us = US_CNT_W'(GAP_US);
      default:    dur_us = US_CNT_W'(1);
    endcase
  end

  assign last = (pre == PRE_LAST) && (us_cnt == dur_us - 1'b1);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (ir.send) next_state = LEAD_MARK;
      LEAD_MARK:  if (last) next_state = rep ? REP_SPACE : LEAD_SPACE;
      LEAD_SPACE: if (last) next_state = BIT_MARK;
      REP_SPACE:  if (last) next_state = STOP_MARK;
      BIT_MARK:   if (last) next_state = BIT_SPACE;
      BIT_SPACE:  if (last) next_state = (bit_cnt == 5'(NEC_BITS - 1)) ? STOP_MARK : BIT_MARK;
      STOP_MARK:  if (last) next_state = GAP;
      GAP:        if (last) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= next_state;
  end

  // Timing counters restart on every state entry; payload loads on acceptance.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pre     <= '0;
      us_cnt  <= '0;
      sr      <= '0;
      bit_cnt <= '0;
      rep     <= 1'b0;
    end else begin
      if (state == IDLE || next_state != state) begin
        pre    <= '0;
        us_cnt <= '0;
      end else if (pre == PRE_LAST) begin
        pre    <= '0;
        us_cnt <= us_cnt + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end

      if (state == IDLE && ir.send) begin
        sr      <= nec_frame(ir.addr, ir.cmd);
        rep     <= ir.repeat_req;
        bit_cnt <= '0;
      end else if (state == BIT_SPACE && last) begin
        sr      <= sr >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  ir_carrier_gen #(.CARRIER_HALF(CARRIER_HALF)) u_carrier (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (mark),
    .carrier (carrier)
  );

  assign ir.infrared_out = ~mark;
  assign ir.ir_led       = mark & carrier;
  assign ir.busy         = (state != IDLE);
  assign ir.done         = (state == GAP) && last;
endmodule

// File: tb/tb_infrared_send.sv
// Bench for infrared_send: segment-level waveform model checked every cycle,
// plus a run-length decoder that pins frame timing and payload literally.
module tb_infrared_send;
  localparam int D  = 2;    // cycles per us
  localparam int LM = 90;
  localparam int LS = 45;
  localparam int RS = 22;
  localparam int BM = 6;
  localparam int ZS = 6;
  localparam int OS = 17;
  localparam int GP = 400;
  localparam int CH = 3;

  typedef struct packed {
    logic busy;
    logic done;
    logic out;
    logic led;
  } exp_t;

  typedef struct {
    bit lvl;
    int len;
  } run_t;

  localparam exp_t IDLE_E = '{busy: 1'b0, done: 1'b0, out: 1'b1, led: 1'b0};

  logic sys_clk;
  logic sys_rst;
  infrared_send_if ifc();

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;
  bit   cur_busy = 0;
  exp_t exp_q[$];
  run_t runs[$];
  bit   cur_lvl = 1;
  int   run_len = 0;
  int   led_cnt = 0;

  infrared_send #(
    .US_DIV(D), .LEAD_MARK_US(LM), .LEAD_SPACE_US(LS), .REP_SPACE_US(RS),
    .BIT_MARK_US(BM), .ZERO_SPACE_US(ZS), .ONE_SPACE_US(OS), .GAP_US(GP),
    .CARRIER_HALF(CH)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .ir      (ifc.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a frame is a list of mark/space segments of whole microseconds.
  task automatic push_seg(input bit mk, input int us);
    exp_t e;
    for (int t = 0; t < us * D; t++) begin
      e.busy = 1'b1;
      e.done = 1'b0;
      e.out  = ~mk;
      e.led  = mk && ((t / CH) % 2 == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic model_frame(input bit rep, input logic [7:0] a, input logic [7:0] c);
    logic [31:0] w;
    w = {~c, c, ~a, a};
    push_seg(1'b1, LM);
    if (rep) begin
      push_seg(1'b0, RS);
    end else begin
      push_seg(1'b0, LS);
      for (int k = 0; k < 32; k++) begin
        push_seg(1'b1, BM);
        push_seg(1'b0, w[k] ? OS : ZS);
      end
    end
    push_seg(1'b1, BM);
    push_seg(1'b0, GP);
    exp_q[exp_q.size() - 1].done = 1'b1;
  endtask

  always @(posedge sys_clk) begin
    if (sys_rst) exp_q.delete();
    else if (chk_en && !cur_busy && ifc.send) model_frame(ifc.repeat_req, ifc.addr, ifc.cmd);
  end

  always @(negedge sys_clk) begin
    exp_t e;
    if (chk_en) begin
      if (sys_rst) begin
        exp_q.delete();
        e = IDLE_E;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e = IDLE_E;
      end
      cur_busy = e.busy;
      chk("wave{busy,done,out,led}", {28'd0, ifc.busy, ifc.done, ifc.infrared_out, ifc.ir_led}, {28'd0, e});
      if (ifc.ir_led) led_cnt++;
      if (ifc.infrared_out == cur_lvl) begin
        run_len++;
      end else begin
        runs.push_back('{lvl: cur_lvl, len: run_len});
        cur_lvl = ifc.infrared_out;
        run_len = 1;
      end
    end
  end

  // Issue one request and follow it to its done pulse; optional extra sends.
  task automatic send_frame(input bit rep, input logic [7:0] a, input logic [7:0] c,
                            input int pulse_at, input bit pulse_done, output int n);
    runs.delete();
    led_cnt = 0;
    ifc.send = 1'b1; ifc.repeat_req = rep; ifc.addr = a; ifc.cmd = c;
    @(posedge sys_clk); #1;
    ifc.send = 1'b0; ifc.repeat_req = ~rep; ifc.addr = ~a; ifc.cmd = ~c;
    n = 1;
    while (!ifc.done && n < 5000) begin
      @(posedge sys_clk); #1;
      n++;
      ifc.send = (n == pulse_at);
    end
    chk("done_seen", {31'd0, ifc.done}, 32'd1);
    ifc.send = pulse_done;
    @(posedge sys_clk); #1;
    ifc.send = 1'b0;
    chk("busy_after_done", {31'd0, ifc.busy}, 32'd0);
  endtask

  task automatic check_data(input string tag, input logic [31:0] exp_word, input int n);
    logic [31:0] w;
    chk({tag, "_len"}, n, 32'd2202);
    chk({tag, "_led_cycles"}, led_cnt, 32'd288);
    chk({tag, "_runs"}, runs.size(), 32'd68);
    if (runs.size() >= 68) begin
      chk({tag, "_lead_mark"}, runs[1].len, 32'd180);
      chk({tag, "_lead_space"}, runs[2].len, 32'd90);
      chk({tag, "_stop_mark"}, runs[67].len, 32'd12);
      w = '0;
      for (int k = 0; k < 32; k++) w[k] = (runs[4 + 2 * k].len == OS * D);
      chk({tag, "_word"}, w, exp_word);
    end
  endtask

  initial begin
    int n;
    logic [7:0] cmds [5];
    logic [31:0] words [5];
    cmds  = '{8'h80, 8'h38, 8'h18, 8'h08, 8'h30};
    words = '{32'h7F80B24D, 32'hC738B24D, 32'hE718B24D, 32'hF708B24D, 32'hCF30B24D};

    sys_rst = 1'b1;
    ifc.send = 1'b0; ifc.repeat_req = 1'b0; ifc.addr = '0; ifc.cmd = '0;
    repeat (3) @(posedge sys_clk);
    #1 chk_en = 1'b1;
    @(posedge sys_clk); #1 sys_rst = 1'b0;

    repeat (1000) @(posedge sys_clk);
    #1;
    chk("idle_out", {31'd0, ifc.infrared_out}, 32'd1);
    chk("idle_busy", {31'd0, ifc.busy}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      send_frame(1'b0, 8'h4D, cmds[i], 0, 1'b0, n);
      check_data("data", words[i], n);
    end

    send_frame(1'b1, 8'h4D, 8'h80, 0, 1'b0, n);
    chk("rep_len", n, 32'd1036);
    chk("rep_led_cycles", led_cnt, 32'd96);
    chk("rep_runs", runs.size(), 32'd4);
    if (runs.size() >= 4) begin
      chk("rep_lead_mark", runs[1].len, 32'd180);
      chk("rep_space", runs[2].len, 32'd44);
      chk("rep_stop_mark", runs[3].len, 32'd12);
    end

    // Sends during bit 10 and in the done cycle must both be dropped.
    send_frame(1'b0, 8'h4D, 8'h80, 625, 1'b1, n);
    check_data("ignored", 32'h7F80B24D, n);
    repeat (5) @(posedge sys_clk);
    #1 chk("no_queued_frame", {31'd0, ifc.busy}, 32'd0);

    // Reset in the middle of a bit mark.
    ifc.send = 1'b1; ifc.repeat_req = 1'b0; ifc.addr = 8'h4D; ifc.cmd = 8'h80;
    @(posedge sys_clk); #1 ifc.send = 1'b0;
    n = 1;
    while (!(n > 300 && !ifc.infrared_out) && n < 2000) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk("reached_bit_mark", {31'd0, ifc.infrared_out}, 32'd0);
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_out", {31'd0, ifc.infrared_out}, 32'd1);
    chk("rst_led", {31'd0, ifc.ir_led}, 32'd0);
    chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
    chk("rst_done", {31'd0, ifc.done}, 32'd0);
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1 chk("post_rst_idle", {31'd0, ifc.busy}, 32'd0);
    send_frame(1'b0, 8'h4D, 8'h80, 0, 1'b0, n);
    check_data("post_rst", 32'h7F80B24D, n);

    repeat (10) @(posedge sys_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
